// File: rtl/pattern_histogram_engine_if.sv
// Single-port data-memory bus shared by the CPU core and the histogram engine.
// Read data returns one cycle after a registered read strobe.
interface pattern_histogram_engine_if #(
    parameter int unsigned AW = 8
) ();
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [7:0]    mem_rd_data;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_data;

    modport master (
        output mem_addr,
        output mem_rd_en,
        input  mem_rd_data,
        output mem_wr_en,
        output mem_wr_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        output mem_rd_data,
        input  mem_wr_en,
        input  mem_wr_data
    );
endinterface

// File: rtl/pattern_histogram_engine.sv
// Start/halt accelerator: scans DATA_LEN bytes and histograms how many of the five 4-bit
// windows in each byte equal the pattern nibble, then writes the five bins back to memory.
module pattern_histogram_engine #(
    parameter int unsigned AW        = 8,
    parameter int unsigned PAT_ADDR  = 9,
    parameter int unsigned DATA_BASE = 32,
    parameter int unsigned DATA_LEN  = 64,
    parameter int unsigned HIST_BASE = 10
) (
    input  logic                         CLK,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         halt,
    pattern_histogram_engine_if.master   mem
);

    localparam logic [AW-1:0] PatAddr  = AW'(PAT_ADDR);
    localparam logic [AW-1:0] DataBase = AW'(DATA_BASE);
    localparam logic [AW-1:0] DataLast = AW'(DATA_BASE + DATA_LEN - 1);
    localparam logic [AW-1:0] HistBase = AW'(HIST_BASE);

    typedef enum logic [2:0] {StIdle, StPat, StPatw, StScan, StDrain, StWr, StDone} state_e;

    state_e        state_q, state_d;
    logic          halt_q, halt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_en_q, rd_en_d;
    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [3:0]    pattern_q, pattern_d;
    logic [2:0]    wr_idx_q, wr_idx_d;
    logic [7:0]    bin_q [5];
    logic [7:0]    bin_d [5];
    logic [7:0]    bin_scored [5];
    logic [2:0]    match_cnt;
    logic [2:0]    wr_idx_nxt;

    // Per-byte score and the bins as they would be after folding it in (saturating).
    always_comb begin
        match_cnt = 3'd0;
        for (int w = 0; w < 5; w++) begin
            match_cnt = match_cnt + 3'(mem.mem_rd_data[w +: 4] == pattern_q);
        end
        for (int i = 0; i < 5; i++) begin
            bin_scored[i] = bin_q[i];
            if (match_cnt == 3'(i + 1) && bin_q[i] != 8'hFF) begin
                bin_scored[i] = bin_q[i] + 8'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        halt_d     = 1'b0;
        addr_d     = addr_q;
        rd_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        wr_data_d  = 8'd0;
        pattern_d  = pattern_q;
        wr_idx_d   = wr_idx_q;
        wr_idx_nxt = wr_idx_q + 3'd1;
        for (int i = 0; i < 5; i++) bin_d[i] = bin_q[i];

        if (start) begin
            state_d = StIdle;
            addr_d  = '0;
            for (int i = 0; i < 5; i++) bin_d[i] = 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StPat;
                    addr_d  = PatAddr;
                    rd_en_d = 1'b1;
                end
                StPat: begin
                    state_d = StPatw;
                    addr_d  = DataBase;
                    rd_en_d = 1'b1;
                end
                StPatw: begin
                    state_d   = StScan;
                    pattern_d = mem.mem_rd_data[3:0];
                    addr_d    = DataBase + AW'(1);
                    rd_en_d   = 1'b1;
                end
                StScan: begin
                    for (int i = 0; i < 5; i++) bin_d[i] = bin_scored[i];
                    if (addr_q == DataLast) begin
                        state_d = StDrain;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        rd_en_d = 1'b1;
                    end
                end
                StDrain: begin
                    // The first write must already include the final byte's score.
                    for (int i = 0; i < 5; i++) bin_d[i] = bin_scored[i];
                    state_d   = StWr;
                    wr_idx_d  = 3'd0;
                    addr_d    = HistBase;
                    wr_en_d   = 1'b1;
                    wr_data_d = bin_scored[0];
                end
                StWr: begin
                    if (wr_idx_q == 3'd4) begin
                        state_d = StDone;
                        halt_d  = 1'b1;
                    end else begin
                        wr_idx_d  = wr_idx_nxt;
                        addr_d    = addr_q + AW'(1);
                        wr_en_d   = 1'b1;
                        wr_data_d = bin_q[wr_idx_nxt];
                    end
                end
                StDone: begin
                    halt_d = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            halt_q    <= 1'b0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 8'd0;
            pattern_q <= 4'd0;
            wr_idx_q  <= 3'd0;
            for (int i = 0; i < 5; i++) bin_q[i] <= 8'd0;
        end else begin
            state_q   <= state_d;
            halt_q    <= halt_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            pattern_q <= pattern_d;
            wr_idx_q  <= wr_idx_d;
            for (int i = 0; i < 5; i++) bin_q[i] <= bin_d[i];
        end
    end

    assign halt            = halt_q;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_rd_en   = rd_en_q;
    assign mem.mem_wr_en   = wr_en_q;
    assign mem.mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_pattern_histogram_engine.sv
// Directed and random checks of pattern_histogram_engine against a behavioural memory
// and a bench-side histogram model.
module tb_pattern_histogram_engine;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b1;
    logic halt;

    pattern_histogram_engine_if #(.AW(8)) bus ();

    pattern_histogram_engine #(
        .AW(8), .PAT_ADDR(9), .DATA_BASE(32), .DATA_LEN(64), .HIST_BASE(10)
    ) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .start (start),
        .halt  (halt),
        .mem   (bus.master)
    );

    always #5 CLK = ~CLK;

    logic [7:0] mem_arr  [256];
    logic [7:0] init_arr [256];
    logic       load = 1'b0;
    logic [7:0] rd_data_q = 8'd0;
    int         cyc = 0;
    int         both_strobes = 0;
    int         wr_addr_log [$];
    int         wr_cyc_log  [$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_bins [5];

    assign bus.mem_rd_data = rd_data_q;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (load) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_arr[i];
        end else begin
            if (bus.mem_rd_en) rd_data_q <= mem_arr[bus.mem_addr];
            if (bus.mem_wr_en) begin
                mem_arr[bus.mem_addr] <= bus.mem_wr_data;
                wr_addr_log.push_back(int'(bus.mem_addr));
                wr_cyc_log.push_back(cyc);
            end
            if (bus.mem_rd_en && bus.mem_wr_en) both_strobes <= both_strobes + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Load memory from init_arr with the engine held idle; sentinels mark the bins.
    task automatic prep(input logic [3:0] pat);
        @(negedge CLK);
        start = 1'b1;
        init_arr[9] = {4'hA, pat};
        for (int i = 10; i < 15; i++) init_arr[i] = 8'hEE;
        load = 1'b1;
        @(negedge CLK);
        load = 1'b0;
        @(negedge CLK);
        wr_addr_log.delete();
        wr_cyc_log.delete();
    endtask

    task automatic run_engine(output int edges);
        @(negedge CLK);
        start = 1'b0;
        edges = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK);
            edges++;
            #1;
            if (halt) break;
        end
    endtask

    task automatic compute_ref(input logic [3:0] pat);
        int m;
        for (int k = 0; k < 5; k++) exp_bins[k] = 8'd0;
        for (int a = 32; a < 96; a++) begin
            m = 0;
            for (int w = 0; w < 5; w++) if (((init_arr[a] >> w) & 8'h0F) == {4'h0, pat}) m++;
            if (m > 0 && exp_bins[m-1] != 8'hFF) exp_bins[m-1] = exp_bins[m-1] + 8'd1;
        end
    endtask

    task automatic check_bins(input string t, input int b1, input int b2, input int b3,
                              input int b4, input int b5);
        check_eq($sformatf("%s bin1", t), 32'(mem_arr[10]), 32'(b1));
        check_eq($sformatf("%s bin2", t), 32'(mem_arr[11]), 32'(b2));
        check_eq($sformatf("%s bin3", t), 32'(mem_arr[12]), 32'(b3));
        check_eq($sformatf("%s bin4", t), 32'(mem_arr[13]), 32'(b4));
        check_eq($sformatf("%s bin5", t), 32'(mem_arr[14]), 32'(b5));
    endtask

    initial begin
        int edges;
        logic [3:0] rpat;

        for (int i = 0; i < 256; i++) init_arr[i] = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("reset halt", 32'(halt), 0);
        check_eq("reset addr", 32'(bus.mem_addr), 0);
        check_eq("reset rd_en", 32'(bus.mem_rd_en), 0);
        check_eq("reset wr_en", 32'(bus.mem_wr_en), 0);
        check_eq("reset wr_data", 32'(bus.mem_wr_data), 0);
        @(negedge CLK);
        rst_n = 1'b1;

        // 1: pattern never matches zero bytes
        prep(4'b0010);
        run_engine(edges);
        check_eq("t1 latency", 32'(edges), 72);
        check_bins("t1", 0, 0, 0, 0, 0);

        // 2: every window matches, plus write ordering
        prep(4'b0000);
        run_engine(edges);
        check_eq("t2 latency", 32'(edges), 72);
        check_bins("t2", 0, 0, 0, 0, 64);
        check_eq("t2 write count", 32'(wr_addr_log.size()), 5);
        if (wr_addr_log.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                check_eq($sformatf("t2 wr addr %0d", k), 32'(wr_addr_log[k]), 32'(10 + k));
                if (k > 0) check_eq($sformatf("t2 wr gap %0d", k),
                                    32'(wr_cyc_log[k] - wr_cyc_log[k-1]), 1);
            end
        end

        // 3: mixed scores
        for (int i = 32; i < 96; i++) init_arr[i] = 8'hFF;
        init_arr[32] = 8'h22;
        init_arr[33] = 8'h12;
        init_arr[34] = 8'h20;
        prep(4'b0010);
        run_engine(edges);
        check_bins("t3", 1, 2, 0, 0, 0);

        // 4: abort mid-scan, then restart must start from cleared bins
        for (int i = 32; i < 96; i++) init_arr[i] = 8'h00;
        prep(4'b0000);
        @(negedge CLK);
        start = 1'b0;
        repeat (22) @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        check_eq("t4 halt", 32'(halt), 0);
        check_eq("t4 rd_en", 32'(bus.mem_rd_en), 0);
        repeat (100) @(posedge CLK);
        #1;
        check_eq("t4 no writes", 32'(wr_addr_log.size()), 0);
        check_eq("t4 halt idle", 32'(halt), 0);
        run_engine(edges);
        check_eq("t4 restart latency", 32'(edges), 72);
        check_bins("t4", 0, 0, 0, 0, 64);

        // 5: reset at the edge that would issue the third bin write
        prep(4'b0000);
        @(negedge CLK);
        start = 1'b0;
        edges = 0;
        while (!(bus.mem_wr_en && bus.mem_addr == 8'd11) && edges < 200) begin
            @(posedge CLK);
            #1;
            edges++;
        end
        check_eq("t5 reached k2", 32'(edges < 200), 1);
        @(negedge CLK);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge CLK);
        #1;
        check_eq("t5 halt", 32'(halt), 0);
        check_eq("t5 addr", 32'(bus.mem_addr), 0);
        check_eq("t5 wr_en", 32'(bus.mem_wr_en), 0);
        check_eq("t5 rd_en", 32'(bus.mem_rd_en), 0);
        check_eq("t5 wr_data", 32'(bus.mem_wr_data), 0);
        @(negedge CLK);
        rst_n = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check_eq("t5 mem12", 32'(mem_arr[12]), 32'hEE);
        check_eq("t5 mem13", 32'(mem_arr[13]), 32'hEE);
        check_eq("t5 mem14", 32'(mem_arr[14]), 32'hEE);

        // 6: random data against the reference model
        for (int i = 32; i < 96; i++) init_arr[i] = 8'($urandom);
        rpat = 4'($urandom_range(0, 15));
        compute_ref(rpat);
        prep(rpat);
        run_engine(edges);
        check_eq("t6 latency", 32'(edges), 72);
        check_bins("t6", int'(exp_bins[0]), int'(exp_bins[1]), int'(exp_bins[2]),
                   int'(exp_bins[3]), int'(exp_bins[4]));
        repeat (10) @(posedge CLK);
        #1;
        check_eq("t6 halt held", 32'(halt), 1);
        check_eq("t6 wr idle", 32'(bus.mem_wr_en), 0);
        check_eq("t6 writes", 32'(wr_addr_log.size()), 5);

        check_eq("rd/wr exclusive", 32'(both_strobes), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
